// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: command, stop-reason and state encodings shared by the run controller
package cpu_ctrl_pkg;
  localparam logic [1:0] CMD_RUN   = 2'd0;
  localparam logic [1:0] CMD_STEP  = 2'd1;
  localparam logic [1:0] CMD_HALT  = 2'd2;
  localparam logic [1:0] CMD_CLEAR = 2'd3;
  localparam logic [2:0] SR_NONE      = 3'd0;
  localparam logic [2:0] SR_HALT_INSN = 3'd1;
  localparam logic [2:0] SR_BREAK     = 3'd2;
  localparam logic [2:0] SR_STEP_DONE = 3'd3;
  localparam logic [2:0] SR_USER      = 3'd4;
  localparam logic [2:0] SR_TIMEOUT   = 3'd5;
  typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_RUN, ST_STEP, ST_DONE} state_t;
endpackage

// File: rtl/cpu_stop_detect.sv
// cpu_stop_detect: breakpoint match and prioritized stop-reason selection for a busy cycle
module cpu_stop_detect
  import cpu_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 0
) (
  input  state_t            state,
  input  logic              first,
  input  logic [ADDR_W-1:0] pc,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic              halt_insn,
  input  logic              halt_acc,
  input  logic [CNT_W-1:0]  steps_left,
  input  logic [CNT_W-1:0]  cmd_cycles,
  output logic              bp_hit,
  output logic              stop,
  output logic [2:0]        reason
);
  logic busy, timeout;
  // a breakpoint suppresses the commit, so halt_insn only counts when no breakpoint hit
  always_comb begin
    busy    = state == ST_RUN || state == ST_STEP;
    bp_hit  = busy & bp_en & (pc == bp_addr) & ~first;
    timeout = (MAX_CYCLES != 0) && (cmd_cycles + CNT_W'(1) == CNT_W'(MAX_CYCLES));
    reason  = bp_hit ? SR_BREAK
            : halt_insn ? SR_HALT_INSN
            : halt_acc ? SR_USER
            : (state == ST_STEP && steps_left == CNT_W'(1)) ? SR_STEP_DONE
            : timeout ? SR_TIMEOUT
            : SR_NONE;
    stop    = busy && reason != SR_NONE;
  end
endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step controller producing CPU reset and per-cycle commit enable
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES = 4,
  parameter int ADDR_W       = 32,
  parameter int CNT_W        = 32,
  parameter int MAX_CYCLES   = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [CNT_W-1:0]  cmd_steps,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] pc,
  input  logic              halt_insn,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  output logic              cpu_rst_n,
  output logic              cpu_en,
  output logic              busy,
  output logic              done,
  output logic [2:0]        stop_reason,
  output logic [CNT_W-1:0]  cycle_count
);
  localparam int RST_W = $clog2(RESET_CYCLES + 1);
  state_t state, state_nx;
  logic [RST_W-1:0] rst_cnt;
  logic [CNT_W-1:0] steps_left, cmd_cycles;
  logic first, bp_hit, stop, accept, halt_acc;
  logic [2:0] reason;

  cpu_stop_detect #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .MAX_CYCLES(MAX_CYCLES)) u_stop (
    .state(state), .first(first), .pc(pc), .bp_en(bp_en), .bp_addr(bp_addr),
    .halt_insn(halt_insn), .halt_acc(halt_acc), .steps_left(steps_left),
    .cmd_cycles(cmd_cycles), .bp_hit(bp_hit), .stop(stop), .reason(reason)
  );

  // decoded status; only HALT is accepted while executing, others stay pending
  always_comb begin
    busy      = state == ST_RUN || state == ST_STEP;
    done      = state == ST_DONE;
    cmd_ready = state == ST_IDLE || done || (busy && cmd_op == CMD_HALT);
    cpu_en    = busy & ~bp_hit;
    accept    = cmd_valid & cmd_ready;
    halt_acc  = accept & busy;
  end

  // next state: INIT counts out, busy states stop on any reason, idle states take commands
  always_comb begin
    state_nx = state == ST_INIT ? (rst_cnt == RST_W'(RESET_CYCLES - 1) ? ST_IDLE : ST_INIT)
             : busy ? (stop ? ST_DONE : state)
             : !accept ? state
             : cmd_op == CMD_RUN ? ST_RUN
             : cmd_op == CMD_STEP ? ST_STEP
             : cmd_op == CMD_CLEAR ? ST_INIT
             : state;
  end

  // state register plus counters, registered CPU reset and latched stop reason
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= ST_INIT;
      rst_cnt     <= '0;
      cpu_rst_n   <= 1'b0;
      stop_reason <= SR_NONE;
      cycle_count <= '0;
      steps_left  <= '0;
      cmd_cycles  <= '0;
      first       <= 1'b0;
    end else begin
      state     <= state_nx;
      cpu_rst_n <= state_nx != ST_INIT;
      rst_cnt   <= state == ST_INIT ? rst_cnt + RST_W'(1) : '0;
      if (cpu_en) begin
        cycle_count <= &cycle_count ? cycle_count : cycle_count + CNT_W'(1);
        cmd_cycles  <= cmd_cycles + CNT_W'(1);
        if (state == ST_STEP) steps_left <= steps_left - CNT_W'(1);
      end
      if (busy) first <= 1'b0;
      if (stop) stop_reason <= reason;
      if (!busy && accept && cmd_op != CMD_HALT) begin
        stop_reason <= SR_NONE;
        cmd_cycles  <= '0;
        first       <= 1'b1;
        steps_left  <= cmd_steps == '0 ? CNT_W'(1) : cmd_steps;
        if (cmd_op == CMD_CLEAR) cycle_count <= '0;
      end
    end
  end
endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run/step controller for the single-cycle CPU. It generates the CPU's reset and per-cycle commit enable, so one enabled clock commits one instruction. Host or bench commands are RUN, STEP n, HALT and CLEAR. The block stops on a halt instruction, a PC breakpoint, step exhaustion, a user halt or a timeout, and reports cycle count and stop reason. It sits between the simulation top and the CPU core, replacing free-running clock-driven execution.

Parameters:
RESET_CYCLES, 4, clocks cpu_rst_n is held low after reset or CLEAR (min 1)
ADDR_W, 32, PC/breakpoint width
CNT_W, 32, cycle counter and step/timeout width
MAX_CYCLES, 0, per-command cycle limit; 0 = disabled

Ports:
clock  in  1  single clock, rising edge
reset_n  in  1  synchronous active-low reset
cmd_valid  in  1  command offered
cmd_op  in  2  0=RUN 1=STEP 2=HALT 3=CLEAR
cmd_steps  in  CNT_W  instruction count for STEP; 0 treated as 1
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
pc  in  ADDR_W  current CPU PC (instruction about to execute)
halt_insn  in  1  current instruction is halt/syscall-exit
bp_en  in  1  breakpoint enable
bp_addr  in  ADDR_W  breakpoint PC
cpu_rst_n  out  1  CPU reset, active low
cpu_en  out  1  CPU commit enable
busy  out  1  state is RUN or STEP
done  out  1  state is DONE
stop_reason  out  3  0 NONE 1 HALT_INSN 2 BREAK 3 STEP_DONE 4 USER 5 TIMEOUT
cycle_count  out  CNT_W  enabled cycles since last INIT, saturating

Behaviour:
- Reset (reset_n=0 at posedge): state=INIT, rst counter=0, cpu_rst_n=0, cpu_en=0, cmd_ready=0, busy=0, done=0, stop_reason=0, cycle_count=0, steps_left=0, cmd_cycles=0, first=0.
- INIT: cpu_rst_n=0 for exactly RESET_CYCLES clocks, then IDLE. cpu_rst_n is registered and goes high on entry to IDLE.
- IDLE/DONE: cmd_ready=1.
  - RUN -> RUN.
  - STEP -> STEP with steps_left=max(cmd_steps,1).
  - CLEAR -> INIT; cycle_count=0, stop_reason=0.
  - HALT is accepted as a no-op.
  - Accepting RUN/STEP clears done, sets stop_reason=0, cmd_cycles=0, first=1.
- RUN/STEP: cmd_ready = (cmd_op==HALT). Other ops are not accepted and stay pending.
- cpu_en is combinational: busy & ~bp_hit, where bp_hit = bp_en & (pc==bp_addr) & ~first.
  - first clears after the first busy cycle, so resuming from a breakpoint executes that instruction.
- Per busy cycle with cpu_en=1: cycle_count+=1 (saturate at all-ones), cmd_cycles+=1; STEP also does steps_left-=1.
- Stop evaluation each busy cycle. Next state is DONE with the first matching reason, in priority order:
  1. bp_hit -> BREAK (instruction not executed, cpu_en=0)
  2. halt_insn & cpu_en -> HALT_INSN (halt instruction commits)
  3. HALT command accepted -> USER (current instruction commits)
  4. STEP & steps_left==1 -> STEP_DONE
  5. MAX_CYCLES!=0 & cmd_cycles+1==MAX_CYCLES -> TIMEOUT
- Result: exactly N commits for STEP N absent earlier stops. The DONE entry cycle has cpu_en=0.
- DONE: stop_reason held, done=1, cpu_en=0. pc and halt_insn are ignored.
- reset_n low mid-run: immediate INIT on the next edge with all outputs at reset values. An in-flight command is dropped.
- Latency: command accept -> first cpu_en=1 is one clock.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - cmd_op encodings (CMD_RUN/STEP/HALT/CLEAR);
  - stop_reason encodings;
  - state enum INIT, IDLE, RUN, STEP, DONE.
- Natural sub-module: cpu_stop_detect. It is combinational and takes state, first, pc, bp, halt_insn, HALT accept, steps_left and cmd_cycles. It produces bp_hit and the prioritized stop_reason/stop flag, keeping the FSM file pure sequencing.

Test Plan:
1. Reset released with RESET_CYCLES=4 -> cpu_rst_n low 4 clocks after reset_n rises, then high; cmd_ready=1, cycle_count=0.
2. STEP cmd_steps=3 -> exactly 3 cpu_en cycles; done=1, stop_reason=3, cycle_count=3. A following STEP with cmd_steps=0 gives 1 cycle, cycle_count=4.
3. RUN with bp_en=1, bp_addr=0x0000_0010, PC advancing by 4 from 0 -> cpu_en high for 4 cycles, low at pc=0x10; stop_reason=2. Then RUN -> cpu_en high at pc=0x10 (first mask) and continues.
4. RUN, halt_insn asserted on cycle 6 while HALT command issued in the same cycle -> 6 commits, stop_reason=1 (HALT_INSN beats USER).
5. MAX_CYCLES=10, RUN with no stop sources -> 10 commits, stop_reason=5. CLEAR -> INIT, cycle_count=0, cpu_rst_n low 4 clocks.
6. reset_n low during RUN at cycle 3 -> next edge cpu_en=0, cpu_rst_n=0, busy=0, stop_reason=0. Any STEP offered while in RUN is not accepted (cmd_ready=0).
